// File: rtl/bpu_ras_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpu_ras_if                                                      |
// | Brief    : Fetch/feedback/prediction bundle of the return address stack.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface bpu_ras_if #(
    parameter int DEPTH = 8,
    parameter int AW    = 30
);
    localparam int c_CW = $clog2(DEPTH + 1);

    logic            fe_valid_i;
    logic            fe_push_i;
    logic            fe_pop_i;
    logic [AW-1:0]   fe_ret_addr_i;
    logic [AW-1:0]   top_o;
    logic            top_valid_o;
    logic [c_CW-1:0] spec_count_o;
    logic            fb_valid_i;
    logic [1:0]      fb_br_type_i;
    logic [AW-1:0]   fb_pc_i;
    logic            fb_flush_i;

    modport slave (
        input  fe_valid_i, fe_push_i, fe_pop_i, fe_ret_addr_i,
        input  fb_valid_i, fb_br_type_i, fb_pc_i, fb_flush_i,
        output top_o, top_valid_o, spec_count_o
    );

    modport master (
        output fe_valid_i, fe_push_i, fe_pop_i, fe_ret_addr_i,
        output fb_valid_i, fb_br_type_i, fb_pc_i, fb_flush_i,
        input  top_o, top_valid_o, spec_count_o
    );
endinterface
`default_nettype wire

// File: rtl/bpu_ras.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bpu_ras                                                         |
// | Brief    : Speculative return address stack with committed shadow repair.  |
// |            Optional macro BPU_RAS_COUNTER_EN adds per-entry repeat counts. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module bpu_ras #(
    parameter int DEPTH = 8,
    parameter int AW    = 30
) (
    input  wire logic    clk,
    input  wire logic    rst,
    bpu_ras_if.slave     ras
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
    // Branch type encoding: 0 PC_RELATIVE, 1 ABSOLUTE, 2 CALL, 3 RETURN.
    localparam logic [1:0] c_BR_CALL   = 2'd2;
    localparam logic [1:0] c_BR_RETURN = 2'd3;

    logic [AW-1:0]   r_spec_addr [DEPTH];
    logic [c_PW-1:0] r_spec_sp;
    logic [c_CW-1:0] r_spec_cnt;
    logic [AW-1:0]   r_com_addr  [DEPTH];
    logic [c_PW-1:0] r_com_sp;
    logic [c_CW-1:0] r_com_cnt;

    logic [AW-1:0]   w_spec_addr_n [DEPTH];
    logic [c_PW-1:0] w_spec_sp_n;
    logic [c_CW-1:0] w_spec_cnt_n;
    logic [AW-1:0]   w_com_addr_n  [DEPTH];
    logic [c_PW-1:0] w_com_sp_n;
    logic [c_CW-1:0] w_com_cnt_n;

    logic [AW-1:0]   w_fb_addr;
    logic            w_com_hit;
    logic            w_com_rc_nz;
    logic            w_spec_hit;
    logic            w_spec_rc_nz;

    assign w_fb_addr = ras.fb_pc_i + AW'(1);

`ifdef BPU_RAS_COUNTER_EN
    logic [2:0] r_spec_rc   [DEPTH];
    logic [2:0] r_com_rc    [DEPTH];
    logic [2:0] w_spec_rc_n [DEPTH];
    logic [2:0] w_com_rc_n  [DEPTH];

    // A repeated call to the same target bumps the top counter instead of allocating.
    assign w_com_hit    = (r_com_cnt != '0) && (r_com_addr[r_com_sp] == w_fb_addr);
    assign w_com_rc_nz  = (r_com_rc[r_com_sp] != 3'd0);
    assign w_spec_hit   = (r_spec_cnt != '0) && (r_spec_addr[r_spec_sp] == ras.fe_ret_addr_i);
    assign w_spec_rc_nz = (r_spec_rc[r_spec_sp] != 3'd0);
`else
    assign w_com_hit    = 1'b0;
    assign w_com_rc_nz  = 1'b0;
    assign w_spec_hit   = 1'b0;
    assign w_spec_rc_nz = 1'b0;
`endif

    always_comb begin
        w_com_addr_n = r_com_addr;
        w_com_sp_n   = r_com_sp;
        w_com_cnt_n  = r_com_cnt;
`ifdef BPU_RAS_COUNTER_EN
        w_com_rc_n   = r_com_rc;
`endif
        if (ras.fb_valid_i && (ras.fb_br_type_i == c_BR_CALL)) begin
            if (w_com_hit) begin
`ifdef BPU_RAS_COUNTER_EN
                if (r_com_rc[r_com_sp] != 3'd7)
                    w_com_rc_n[r_com_sp] = r_com_rc[r_com_sp] + 3'd1;
`endif
            end else begin
                w_com_sp_n               = r_com_sp + c_PW'(1);
                w_com_addr_n[w_com_sp_n] = w_fb_addr;
`ifdef BPU_RAS_COUNTER_EN
                w_com_rc_n[w_com_sp_n]   = 3'd0;
`endif
                if (r_com_cnt != c_FULL)
                    w_com_cnt_n = r_com_cnt + c_CW'(1);
            end
        end else if (ras.fb_valid_i && (ras.fb_br_type_i == c_BR_RETURN)) begin
            if (r_com_cnt != '0) begin
                if (w_com_rc_nz) begin
`ifdef BPU_RAS_COUNTER_EN
                    w_com_rc_n[r_com_sp] = r_com_rc[r_com_sp] - 3'd1;
`endif
                end else begin
                    w_com_sp_n  = r_com_sp - c_PW'(1);
                    w_com_cnt_n = r_com_cnt - c_CW'(1);
                end
            end
        end
    end

    always_comb begin
        w_spec_addr_n = r_spec_addr;
        w_spec_sp_n   = r_spec_sp;
        w_spec_cnt_n  = r_spec_cnt;
`ifdef BPU_RAS_COUNTER_EN
        w_spec_rc_n   = r_spec_rc;
`endif
        // Repair takes the committed state including this cycle's feedback.
        if (ras.fb_flush_i) begin
            w_spec_addr_n = w_com_addr_n;
            w_spec_sp_n   = w_com_sp_n;
            w_spec_cnt_n  = w_com_cnt_n;
`ifdef BPU_RAS_COUNTER_EN
            w_spec_rc_n   = w_com_rc_n;
`endif
        end else if (ras.fe_valid_i) begin
            if (ras.fe_push_i && ras.fe_pop_i) begin
                w_spec_addr_n[r_spec_sp] = ras.fe_ret_addr_i;
`ifdef BPU_RAS_COUNTER_EN
                w_spec_rc_n[r_spec_sp]   = 3'd0;
`endif
                if (r_spec_cnt == '0)
                    w_spec_cnt_n = c_CW'(1);
            end else if (ras.fe_push_i) begin
                if (w_spec_hit) begin
`ifdef BPU_RAS_COUNTER_EN
                    if (r_spec_rc[r_spec_sp] != 3'd7)
                        w_spec_rc_n[r_spec_sp] = r_spec_rc[r_spec_sp] + 3'd1;
`endif
                end else begin
                    w_spec_sp_n                = r_spec_sp + c_PW'(1);
                    w_spec_addr_n[w_spec_sp_n] = ras.fe_ret_addr_i;
`ifdef BPU_RAS_COUNTER_EN
                    w_spec_rc_n[w_spec_sp_n]   = 3'd0;
`endif
                    if (r_spec_cnt != c_FULL)
                        w_spec_cnt_n = r_spec_cnt + c_CW'(1);
                end
            end else if (ras.fe_pop_i && (r_spec_cnt != '0)) begin
                if (w_spec_rc_nz) begin
`ifdef BPU_RAS_COUNTER_EN
                    w_spec_rc_n[r_spec_sp] = r_spec_rc[r_spec_sp] - 3'd1;
`endif
                end else begin
                    w_spec_sp_n  = r_spec_sp - c_PW'(1);
                    w_spec_cnt_n = r_spec_cnt - c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_spec_addr[i] <= '0;
                r_com_addr[i]  <= '0;
`ifdef BPU_RAS_COUNTER_EN
                r_spec_rc[i]   <= '0;
                r_com_rc[i]    <= '0;
`endif
            end
            r_spec_sp  <= '0;
            r_spec_cnt <= '0;
            r_com_sp   <= '0;
            r_com_cnt  <= '0;
        end else begin
            r_spec_addr <= w_spec_addr_n;
            r_spec_sp   <= w_spec_sp_n;
            r_spec_cnt  <= w_spec_cnt_n;
            r_com_addr  <= w_com_addr_n;
            r_com_sp    <= w_com_sp_n;
            r_com_cnt   <= w_com_cnt_n;
`ifdef BPU_RAS_COUNTER_EN
            r_spec_rc   <= w_spec_rc_n;
            r_com_rc    <= w_com_rc_n;
`endif
        end
    end

    assign ras.top_o        = (r_spec_cnt != '0) ? r_spec_addr[r_spec_sp] : '0;
    assign ras.top_valid_o  = (r_spec_cnt != '0);
    assign ras.spec_count_o = r_spec_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bpu_ras.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bpu_ras                                                      |
// | Brief    : Directed and random checks of bpu_ras against a queue model.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_bpu_ras;
    localparam int DEPTH = 8;
    localparam int AW    = 30;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [1:0] BR_PCREL = 2'd0;
    localparam logic [1:0] BR_ABS   = 2'd1;
    localparam logic [1:0] BR_CALL  = 2'd2;
    localparam logic [1:0] BR_RET   = 2'd3;

    typedef struct {
        logic [AW-1:0] addr;
        int            rc;
    } ent_t;
    typedef ent_t stk_t[$];

    logic  clk = 1'b0;
    logic  rst;
    int    n_tests = 0;
    int    n_fail  = 0;
    string cur_step = "init";
    stk_t  spec_q;
    stk_t  com_q;

    always #5 clk = ~clk;

    bpu_ras_if #(.DEPTH(DEPTH), .AW(AW)) ras ();
    bpu_ras #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .ras(ras));

    // Stack model: back of the queue is the top; overflow drops the front.
    function automatic stk_t m_push(stk_t q, logic [AW-1:0] a);
`ifdef BPU_RAS_COUNTER_EN
        if (q.size() > 0 && q[q.size()-1].addr == a) begin
            if (q[q.size()-1].rc < 7) q[q.size()-1].rc++;
            return q;
        end
`endif
        q.push_back('{addr: a, rc: 0});
        if (q.size() > DEPTH) void'(q.pop_front());
        return q;
    endfunction

    function automatic stk_t m_pop(stk_t q);
        if (q.size() == 0) return q;
`ifdef BPU_RAS_COUNTER_EN
        if (q[q.size()-1].rc > 0) begin
            q[q.size()-1].rc--;
            return q;
        end
`endif
        void'(q.pop_back());
        return q;
    endfunction

    function automatic stk_t m_pushpop(stk_t q, logic [AW-1:0] a);
        if (q.size() == 0) q.push_back('{addr: a, rc: 0});
        else               q[q.size()-1] = '{addr: a, rc: 0};
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_step, tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        logic [AW-1:0] etop;
        etop = (spec_q.size() > 0) ? spec_q[spec_q.size()-1].addr : '0;
        chk("top",   32'(ras.top_o),        32'(etop));
        chk("valid", 32'(ras.top_valid_o),  32'(spec_q.size() > 0));
        chk("count", 32'(ras.spec_count_o), 32'(spec_q.size()));
    endtask

    task automatic chk_lit(input logic [31:0] top, input logic [31:0] valid, input logic [31:0] cnt);
        chk("lit_top",   32'(ras.top_o),        top);
        chk("lit_valid", 32'(ras.top_valid_o),  valid);
        chk("lit_count", 32'(ras.spec_count_o), cnt);
    endtask

    task automatic cycle(input bit r, input bit fv, input bit fpu, input bit fpo,
                         input logic [AW-1:0] fa, input bit bv, input logic [1:0] bt,
                         input logic [AW-1:0] bpc, input bit fl);
        logic [AW-1:0] call_ret;
        rst               = r;
        ras.fe_valid_i    = fv;
        ras.fe_push_i     = fpu;
        ras.fe_pop_i      = fpo;
        ras.fe_ret_addr_i = fa;
        ras.fb_valid_i    = bv;
        ras.fb_br_type_i  = bt;
        ras.fb_pc_i       = bpc;
        ras.fb_flush_i    = fl;
        @(posedge clk);
        if (r) begin
            spec_q.delete();
            com_q.delete();
        end else begin
            call_ret = bpc + AW'(1);
            if (bv && bt == BR_CALL) com_q = m_push(com_q, call_ret);
            if (bv && bt == BR_RET)  com_q = m_pop(com_q);
            if (fl) spec_q = com_q;
            else if (fv && fpu && fpo) spec_q = m_pushpop(spec_q, fa);
            else if (fv && fpu)        spec_q = m_push(spec_q, fa);
            else if (fv && fpo)        spec_q = m_pop(spec_q);
        end
        #1;
        chk_model();
    endtask

    task automatic do_reset();  cycle(1, 0, 0, 0, '0, 0, BR_PCREL, '0, 0); endtask
    task automatic push(input logic [AW-1:0] a); cycle(0, 1, 1, 0, a, 0, BR_PCREL, '0, 0); endtask
    task automatic pop();       cycle(0, 1, 0, 1, '0, 0, BR_PCREL, '0, 0); endtask
    task automatic flush();     cycle(0, 0, 0, 0, '0, 0, BR_PCREL, '0, 1); endtask

    initial begin
        cur_step = "reset";
        do_reset();
        do_reset();
        chk_lit(32'h0, 32'h0, 32'h0);

        cur_step = "basic";
        push(30'h100); push(30'h200); push(30'h300);
        chk_lit(32'h300, 32'h1, 32'h3);
        pop(); pop();
        chk_lit(32'h100, 32'h1, 32'h1);

        cur_step = "wrap";
        do_reset();
        for (int i = 1; i <= 9; i++) push(AW'(i));
        chk_lit(32'h9, 32'h1, 32'h8);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_top", 32'(ras.top_o), 32'(9 - i));
            pop();
        end
        chk_lit(32'h0, 32'h0, 32'h0);
        pop();
        chk_lit(32'h0, 32'h0, 32'h0);

        cur_step = "repair";
        do_reset();
        cycle(0, 0, 0, 0, '0, 1, BR_CALL, 30'h40, 0);
        push(30'h77); push(30'h88); pop();
        flush();
        chk_lit(32'h41, 32'h1, 32'h1);

        cur_step = "pushpop";
        do_reset();
        cycle(0, 1, 1, 0, 30'h100, 1, BR_CALL, 30'h0ff, 0);
        cycle(0, 1, 1, 0, 30'h200, 1, BR_CALL, 30'h1ff, 0);
        cycle(0, 1, 1, 1, 30'h500, 0, BR_ABS, '0, 0);
        chk_lit(32'h500, 32'h1, 32'h2);
        cycle(0, 1, 1, 1, 30'h600, 0, BR_ABS, '0, 1);
        chk_lit(32'h200, 32'h1, 32'h2);

        cur_step = "rst_mid";
        cycle(1, 1, 1, 0, 30'h999, 1, BR_CALL, 30'h123, 1);
        chk_lit(32'h0, 32'h0, 32'h0);
        flush();
        chk_lit(32'h0, 32'h0, 32'h0);

        cur_step = "pc_wrap";
        cycle(0, 0, 0, 0, '0, 1, BR_CALL, {AW{1'b1}}, 1);
        chk_lit(32'h0, 32'h1, 32'h1);

        cur_step = "recursion";
        do_reset();
        push(30'h80); push(30'h80); push(30'h80);
        pop();
`ifdef BPU_RAS_COUNTER_EN
        chk_lit(32'h80, 32'h1, 32'h1);
        pop(); pop();
        chk_lit(32'h0, 32'h0, 32'h0);
`else
        chk_lit(32'h80, 32'h1, 32'h2);
        pop(); pop();
        chk_lit(32'h0, 32'h0, 32'h0);
`endif

        cur_step = "random";
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  1'($urandom), 1'($urandom), 1'($urandom),
                  AW'($urandom_range(1, 5)),
                  1'($urandom), 2'($urandom),
                  ($urandom_range(0, 15) == 0) ? {AW{1'b1}} : AW'($urandom_range(0, 4)),
                  $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
